alu_exec_ctrl: RTL and testbench
================================

# alu_exec_ctrl

Execute-stage sequencer for the 16-bit ALU. Accepts decoded instructions from decode over a valid/ready handshake, drives the combinational ALU, and owns the architectural flag register {Z,V,N}. It evaluates branch conditions against that register and captures result, destination and branch decision into the EX/MEM register, which has its own valid/ready handshake to the memory stage. Also maintains retired-instruction and taken-branch counters.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  block accepts the instruction this cycle
- in_opcode  in  4  instruction opcode
- in_rs_val, in_rt_val  in  16 each  source operand values
- in_imm  in  4  shift/rotate amount
- in_ccc  in  3  branch condition code
- in_dst  in  4  destination register index
- in_wr_en  in  1  instruction writes the register file
- flush  in  1  discard the in-flight and offered instruction
- alu_A, alu_B  out  16 each  ALU operands, equal to in_rs_val and in_rt_val
- alu_imm  out  4  equal to in_imm
- alu_opcode  out  4  equal to in_opcode
- alu_flag  out  3  flag register {Z,V,N} fed to the ALU
- alu_out  in  16  ALU result
- alu_Z, alu_V, alu_N  in  1 each  ALU flag outputs
- out_valid  out  1  EX/MEM register holds a valid instruction
- out_ready  in  1  memory stage accepts
- out_result  out  16  captured alu_out
- out_opcode, out_dst  out  4 each  captured opcode and destination
- out_wr_en  out  1  captured in_wr_en
- out_br_taken  out  1  captured branch decision, qualified by out_valid
- flags  out  3  architectural {Z,V,N}; flags[2]=Z, flags[1]=V, flags[0]=N
- instr_cnt, taken_cnt  out  CNT_W each  retired-instruction and taken-branch counters

## Operation
- in_ready = !out_valid || out_ready. accept = in_valid && in_ready && !flush.
- On accept, the EX/MEM register loads alu_out, in_opcode, in_dst, in_wr_en and br_taken, and out_valid goes high. flags loads {alu_Z,alu_V,alu_N}; the ALU passes flags through for opcodes that do not update them. instr_cnt increments by 1.
- If out_valid && out_ready && !accept: out_valid goes low.
- Backpressure (out_valid && !out_ready): all EX/MEM fields, flags and counters hold.
- Branch: opcode 4'b1100 (B) or 4'b1101 (BR). br_taken is evaluated from the flag register before the branch; branches do not change flags. Conditions: 000 NE Z=0; 001 EQ Z=1; 010 GT Z=0&&N=0; 011 LT N=1; 100 GE Z=1||N=0; 101 LE Z=1||N=1; 110 OV V=1; 111 always. Non-branches: br_taken=0. Accepting a taken branch increments taken_cnt.
- flush takes priority over everything else. The next edge clears out_valid. The offered instruction is not accepted. flags and counters do not change.
- Counters wrap from all-ones to 0.
- Reset: out_valid=0, out_result=0, out_opcode=0, out_dst=0, out_wr_en=0, out_br_taken=0, flags=3'b000, instr_cnt=0, taken_cnt=0. Reset in the middle of a backpressure stall discards the held instruction.

## Timing
- Latency 1: an instruction accepted at edge N is visible on out_* after edge N.
- Throughput 1/cycle while out_ready=1.
- in_ready is combinational from out_valid and out_ready. alu_* are combinational pass-throughs, and the ALU settles within the same cycle.
- Back-to-back dependency: the instruction accepted at edge N+1 sees flags written at edge N. This allows a flag-setting instruction followed immediately by a branch, with no bubble.
- flush and in_valid asserted in the same cycle: flush wins.
- out_ready=1 and a new accept in the same cycle: the register is replaced and out_valid stays 1.

## Structure
- Shared package holds the opcode constants (ADD 0000 … SW 1001, B 1100, BR 1101), the ccc encodings, the flag bit indices (Z=2, V=1, N=0) and the flag-vector width.
- One combinational sub-module, br_cond: inputs ccc and flags, output taken.

## Test plan
- ADD 0x7FFF+0x0001 accepted, out_ready=1 -> next cycle out_result=0x8000, flags=3'b011 (V=1, N=1), instr_cnt=1.
- SUB 5-5, then B ccc=001 on the next cycle -> flags=3'b100, then out_br_taken=1, taken_cnt=1. Same pair with ccc=000 -> out_br_taken=0.
- XOR 0x00FF^0x00FF after a flag state of 3'b011 -> flags=3'b111 (Z set, V and N kept).
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_result, flags and instr_cnt all hold; out_ready=1 -> next instruction accepted on the following edge.
- flush together with in_valid and an ADD offered, out_valid=1 -> out_valid=0 after the edge, flags and instr_cnt unchanged.
- Preload instr_cnt to 0xFFFF, accept one instruction -> instr_cnt=0x0000. rst_n=0 during a stall -> all outputs at their reset values after the edge.

Source files
------------

// File: rtl/alu_exec_ctrl_pkg.sv
// Shared definitions for the execute-stage sequencer: opcodes, branch
// condition codes and flag-register layout.
package alu_exec_ctrl_pkg;

   localparam int FLAG_W = 3;

   // Bit positions inside the {Z,V,N} flag vector
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 0;

   // Opcodes
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_NOT = 4'b0101;
   localparam logic [3:0] OP_SLA = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b0111;
   localparam logic [3:0] OP_LW  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1001;
   localparam logic [3:0] OP_B   = 4'b1100;
   localparam logic [3:0] OP_BR  = 4'b1101;

   // Branch condition codes
   localparam logic [2:0] CCC_NE = 3'b000;
   localparam logic [2:0] CCC_EQ = 3'b001;
   localparam logic [2:0] CCC_GT = 3'b010;
   localparam logic [2:0] CCC_LT = 3'b011;
   localparam logic [2:0] CCC_GE = 3'b100;
   localparam logic [2:0] CCC_LE = 3'b101;
   localparam logic [2:0] CCC_OV = 3'b110;
   localparam logic [2:0] CCC_AL = 3'b111;

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_B) || (op == OP_BR);
   endfunction

endpackage

// File: rtl/alu_exec_ctrl_br_cond.sv
// Branch condition evaluator: decides taken/not-taken from a condition
// code and the current {Z,V,N} flag register.
module alu_exec_ctrl_br_cond
   import alu_exec_ctrl_pkg::*;
(
   input  logic [2:0]        ccc_i,
   input  logic [FLAG_W-1:0] flags_i,
   output logic              taken_o
);

   logic z, v, n;
   assign z = flags_i[FLAG_Z];
   assign v = flags_i[FLAG_V];
   assign n = flags_i[FLAG_N];

   // Condition decode
   always_comb begin
      taken_o = 1'b0;
      case (ccc_i)
         CCC_NE:  taken_o = !z;
         CCC_EQ:  taken_o = z;
         CCC_GT:  taken_o = !z && !n;
         CCC_LT:  taken_o = n;
         CCC_GE:  taken_o = z || !n;
         CCC_LE:  taken_o = z || n;
         CCC_OV:  taken_o = v;
         CCC_AL:  taken_o = 1'b1;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: drives the combinational ALU, owns the {Z,V,N}
// flag register, resolves branches and fills the EX/MEM register.
//
// Handshakes: on both sides a transfer happens on a rising edge where
// valid and ready are both high. valid, once raised, holds with its
// payload stable until the transfer (or a flush/reset drops it); ready may
// depend combinationally on the downstream ready (in_ready does).
module alu_exec_ctrl
   import alu_exec_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_opcode,
   input  logic [15:0]       in_rs_val,
   input  logic [15:0]       in_rt_val,
   input  logic [3:0]        in_imm,
   input  logic [2:0]        in_ccc,
   input  logic [3:0]        in_dst,
   input  logic              in_wr_en,
   input  logic              flush,
   output logic [15:0]       alu_A,
   output logic [15:0]       alu_B,
   output logic [3:0]        alu_imm,
   output logic [3:0]        alu_opcode,
   output logic [FLAG_W-1:0] alu_flag,
   input  logic [15:0]       alu_out,
   input  logic              alu_Z,
   input  logic              alu_V,
   input  logic              alu_N,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_result,
   output logic [3:0]        out_opcode,
   output logic [3:0]        out_dst,
   output logic              out_wr_en,
   output logic              out_br_taken,
   output logic [FLAG_W-1:0] flags,
   output logic [CNT_W-1:0]  instr_cnt,
   output logic [CNT_W-1:0]  taken_cnt
);

   logic              out_valid_q, out_valid_d;
   logic [15:0]       out_result_q, out_result_d;
   logic [3:0]        out_opcode_q, out_opcode_d;
   logic [3:0]        out_dst_q, out_dst_d;
   logic              out_wr_en_q, out_wr_en_d;
   logic              out_br_q, out_br_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic [CNT_W-1:0]  icnt_q, icnt_d;
   logic [CNT_W-1:0]  tcnt_q, tcnt_d;

   logic accept;
   logic cond_taken;
   logic br_taken;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // ALU operand pass-through; the flag register feeds the ALU so that
   // flag-preserving ops can hand the old flags straight back.
   assign alu_A      = in_rs_val;
   assign alu_B      = in_rt_val;
   assign alu_imm    = in_imm;
   assign alu_opcode = in_opcode;
   assign alu_flag   = flags_q;

   alu_exec_ctrl_br_cond u_br_cond (
      .ccc_i   (in_ccc),
      .flags_i (flags_q),
      .taken_o (cond_taken)
   );

   // Branch decision uses the flags as they stand before this instruction
   assign br_taken = is_branch(in_opcode) && cond_taken;

   // Next-state for EX/MEM register, flags and counters; flush dominates
   always_comb begin
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_opcode_d = out_opcode_q;
      out_dst_d    = out_dst_q;
      out_wr_en_d  = out_wr_en_q;
      out_br_d     = out_br_q;
      flags_d      = flags_q;
      icnt_d       = icnt_q;
      tcnt_d       = tcnt_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d  = 1'b1;
         out_result_d = alu_out;
         out_opcode_d = in_opcode;
         out_dst_d    = in_dst;
         out_wr_en_d  = in_wr_en;
         out_br_d     = br_taken;
         flags_d      = {alu_Z, alu_V, alu_N};
         icnt_d       = icnt_q + CNT_W'(1);
         if (br_taken) begin
            tcnt_d = tcnt_q + CNT_W'(1);
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_result_q <= 16'h0000;
         out_opcode_q <= 4'h0;
         out_dst_q    <= 4'h0;
         out_wr_en_q  <= 1'b0;
         out_br_q     <= 1'b0;
         flags_q      <= '0;
         icnt_q       <= '0;
         tcnt_q       <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_opcode_q <= out_opcode_d;
         out_dst_q    <= out_dst_d;
         out_wr_en_q  <= out_wr_en_d;
         out_br_q     <= out_br_d;
         flags_q      <= flags_d;
         icnt_q       <= icnt_d;
         tcnt_q       <= tcnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_opcode   = out_opcode_q;
   assign out_dst      = out_dst_q;
   assign out_wr_en    = out_wr_en_q;
   assign out_br_taken = out_br_q && out_valid_q;
   assign flags        = flags_q;
   assign instr_cnt    = icnt_q;
   assign taken_cnt    = tcnt_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a behavioural ALU closes the loop, a reference
// model predicts flags, counters and EX/MEM contents, and a queue holds
// expected EX/MEM payloads until the memory stage takes them.
module tb_alu_exec_ctrl;

   localparam int CNT_W = 8;
   localparam int W     = 26; // {result16, opcode4, dst4, wr_en, br_taken}

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_opcode;
   logic [15:0]       in_rs_val;
   logic [15:0]       in_rt_val;
   logic [3:0]        in_imm;
   logic [2:0]        in_ccc;
   logic [3:0]        in_dst;
   logic              in_wr_en;
   logic              flush;
   logic [15:0]       alu_A;
   logic [15:0]       alu_B;
   logic [3:0]        alu_imm;
   logic [3:0]        alu_opcode;
   logic [2:0]        alu_flag;
   logic [15:0]       alu_out;
   logic              alu_Z;
   logic              alu_V;
   logic              alu_N;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_result;
   logic [3:0]        out_opcode;
   logic [3:0]        out_dst;
   logic              out_wr_en;
   logic              out_br_taken;
   logic [2:0]        flags;
   logic [CNT_W-1:0]  instr_cnt;
   logic [CNT_W-1:0]  taken_cnt;

   int total = 0;
   int bad   = 0;

   logic [W-1:0]     exp_q[$];
   logic             exp_valid;
   logic [2:0]       exp_flags;
   logic [CNT_W-1:0] exp_icnt;
   logic [CNT_W-1:0] exp_tcnt;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   alu_exec_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
      .in_ccc(in_ccc), .in_dst(in_dst), .in_wr_en(in_wr_en), .flush(flush),
      .alu_A(alu_A), .alu_B(alu_B), .alu_imm(alu_imm), .alu_opcode(alu_opcode),
      .alu_flag(alu_flag), .alu_out(alu_out), .alu_Z(alu_Z), .alu_V(alu_V),
      .alu_N(alu_N), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_opcode(out_opcode), .out_dst(out_dst),
      .out_wr_en(out_wr_en), .out_br_taken(out_br_taken), .flags(flags),
      .instr_cnt(instr_cnt), .taken_cnt(taken_cnt)
   );

   // ---------------- behavioural ALU ----------------
   // Returns {result, Z, V, N}. Arithmetic updates all flags, logic ops
   // update Z only, everything else passes the incoming flags through.
   function automatic logic [18:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] imm,
                                         input logic [2:0] f);
      logic [15:0] r;
      logic z, v, n;
      r = 16'h0; z = f[2]; v = f[1]; n = f[0];
      case (op)
         4'h0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); z = (r == 16'h0); n = r[15]; end
         4'h1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); z = (r == 16'h0); n = r[15]; end
         4'h2: begin r = a & b; z = (r == 16'h0); end
         4'h3: begin r = a | b; z = (r == 16'h0); end
         4'h4: begin r = a ^ b; z = (r == 16'h0); end
         4'h5: begin r = ~a;    z = (r == 16'h0); end
         4'h6: r = a << imm;
         4'h7: r = $unsigned($signed(a) >>> imm);
         4'h8, 4'h9: r = a + b;
         4'hC, 4'hD: r = a;
         default: r = 16'h0;
      endcase
      return {r, z, v, n};
   endfunction

   assign {alu_out, alu_Z, alu_V, alu_N} = alu_f(alu_opcode, alu_A, alu_B, alu_imm, alu_flag);

   // Reference branch condition on {Z,V,N}
   function automatic logic cond_f(input logic [2:0] c, input logic [2:0] f);
      logic z, v, n;
      z = f[2]; v = f[1]; n = f[0];
      case (c)
         3'd0: return z == 1'b0;
         3'd1: return z == 1'b1;
         3'd2: return (z == 1'b0) && (n == 1'b0);
         3'd3: return n == 1'b1;
         3'd4: return (z == 1'b1) || (n == 1'b0);
         3'd5: return (z == 1'b1) || (n == 1'b1);
         3'd6: return v == 1'b1;
         default: return 1'b1;
      endcase
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] imm, input logic [2:0] c, input logic [3:0] dst,
                        input logic wr);
      in_valid = 1'b1; in_opcode = op; in_rs_val = a; in_rt_val = b;
      in_imm = imm; in_ccc = c; in_dst = dst; in_wr_en = wr;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_valid = 1'b0;
      exp_flags = 3'b000;
      exp_icnt  = '0;
      exp_tcnt  = '0;
   endtask

   // One clock: predict, check handshake and departing payload, clock, check state
   task automatic step();
      logic         exp_ready, acc, tk;
      logic [18:0]  r;
      logic [W-1:0] e;
      #1;
      exp_ready = !exp_valid || out_ready;
      chk("in_ready", in_ready, exp_ready);
      if (exp_valid && flush) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (exp_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("out_result",   out_result,   e[25:10]);
            chk("out_opcode",   out_opcode,   e[9:6]);
            chk("out_dst",      out_dst,      e[5:2]);
            chk("out_wr_en",    out_wr_en,    e[1]);
            chk("out_br_taken", out_br_taken, e[0]);
         end
      end
      acc = in_valid && exp_ready && !flush;
      if (acc) begin
         r  = alu_f(in_opcode, in_rs_val, in_rt_val, in_imm, exp_flags);
         tk = (in_opcode == 4'hC || in_opcode == 4'hD) && cond_f(in_ccc, exp_flags);
         exp_q.push_back({r[18:3], in_opcode, in_dst, in_wr_en, tk});
         exp_flags = r[2:0];
         exp_icnt  = exp_icnt + 1'b1;
         if (tk) exp_tcnt = exp_tcnt + 1'b1;
      end
      if (flush)                      exp_valid = 1'b0;
      else if (acc)                   exp_valid = 1'b1;
      else if (exp_valid && out_ready) exp_valid = 1'b0;
      @(posedge clk); #1;
      chk("out_valid", out_valid, exp_valid);
      chk("flags",     flags,     exp_flags);
      chk("instr_cnt", instr_cnt, exp_icnt);
      chk("taken_cnt", taken_cnt, exp_tcnt);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [15:0] hold_res;
      logic [3:0]  op;
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(4'h0, 16'h0, 16'h0, 4'h0, 3'h0, 4'h0, 1'b0);
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_result", out_result, 16'h0);
      chk("rst_flags", flags, 3'b000);
      chk("rst_instr_cnt", instr_cnt, 8'h00);
      chk("rst_out_br_taken", out_br_taken, 1'b0);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Signed overflow on ADD
      drive(4'h0, 16'h7FFF, 16'h0001, 4'h0, 3'h0, 4'h3, 1'b1); step();
      chk("add_ovf_result", out_result, 16'h8000);
      chk("add_ovf_flags", flags, 3'b011);
      chk("add_ovf_icnt", instr_cnt, 8'd1);

      // SUB sets Z, branch EQ immediately after sees it
      drive(4'h1, 16'd5, 16'd5, 4'h0, 3'h0, 4'h1, 1'b1); step();
      chk("sub_zero_flags", flags, 3'b100);
      drive(4'hC, 16'h0040, 16'h0, 4'h0, 3'b001, 4'h0, 1'b0); step();
      chk("beq_taken", out_br_taken, 1'b1);
      chk("beq_taken_cnt", taken_cnt, 8'd1);

      // Same pair, NE: not taken
      drive(4'h1, 16'd5, 16'd5, 4'h0, 3'h0, 4'h1, 1'b1); step();
      drive(4'hD, 16'h0080, 16'h0, 4'h0, 3'b000, 4'h0, 1'b0); step();
      chk("bne_not_taken", out_br_taken, 1'b0);
      chk("bne_taken_cnt", taken_cnt, 8'd1);

      // XOR to zero keeps V,N from the preceding overflow
      drive(4'h0, 16'h7FFF, 16'h0001, 4'h0, 3'h0, 4'h2, 1'b1); step();
      drive(4'h4, 16'h00FF, 16'h00FF, 4'h0, 3'h0, 4'h2, 1'b1); step();
      chk("xor_keep_flags", flags, 3'b111);

      // Backpressure for 3 cycles with an instruction offered
      hold_res = 16'h0000;
      out_ready = 1'b0;
      drive(4'h0, 16'd1, 16'd2, 4'h0, 3'h0, 4'h4, 1'b1);
      repeat (3) begin
         step();
         chk("stall_result_hold", out_result, hold_res);
         chk("stall_flags_hold", flags, 3'b111);
      end
      out_ready = 1'b1; step();
      chk("after_stall_result", out_result, 16'd3);

      // Flush beats a simultaneous offer
      flush = 1'b1;
      drive(4'h0, 16'h1234, 16'h1111, 4'h0, 3'h0, 4'h5, 1'b1); step();
      flush = 1'b0;
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_flags", flags, 3'b000);

      // Random traffic with random backpressure, offers and conditions
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 11));
         if (op >= 4'd10) op = op + 4'd2;
         drive(op, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         step();
      end
      flush = 1'b0;
      out_ready = 1'b1;

      // Run the instruction counter up to all-ones, then wrap
      for (int i = 0; i < 300 && exp_icnt != 8'hFF; i++) begin
         drive(4'($urandom_range(0, 9)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 4'($urandom_range(0, 15)), 3'h0,
               4'($urandom_range(0, 15)), 1'b1);
         step();
      end
      chk("cnt_at_max", instr_cnt, 8'hFF);
      drive(4'h3, 16'h00F0, 16'h0F00, 4'h0, 3'h0, 4'h6, 1'b1); step();
      chk("cnt_wrap", instr_cnt, 8'h00);

      // Reset in the middle of a stall
      out_ready = 1'b0;
      drive(4'h0, 16'd7, 16'd8, 4'h0, 3'h0, 4'h7, 1'b1); step();
      rst_n = 1'b0;
      @(posedge clk); #1;
      model_reset();
      chk("rst_stall_out_valid", out_valid, 1'b0);
      chk("rst_stall_out_result", out_result, 16'h0);
      chk("rst_stall_out_opcode", out_opcode, 4'h0);
      chk("rst_stall_out_dst", out_dst, 4'h0);
      chk("rst_stall_out_wr_en", out_wr_en, 1'b0);
      chk("rst_stall_out_br_taken", out_br_taken, 1'b0);
      chk("rst_stall_flags", flags, 3'b000);
      chk("rst_stall_instr_cnt", instr_cnt, 8'h00);
      chk("rst_stall_taken_cnt", taken_cnt, 8'h00);
      rst_n = 1'b1;
      out_ready = 1'b1;
      drive(4'h1, 16'd3, 16'd9, 4'h0, 3'h0, 4'h8, 1'b1); step();
      idle(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
